bcd_addsub_seq: RTL and testbench
=================================

Name: bcd_addsub_seq

Overview:
- Digit-serial, parametrised BCD adder/subtractor for WIDTH-digit unsigned BCD operands.
- Processes DPC digits per clock, least-significant group first, behind a valid/ready handshake on input and output.
- Adds a subtract mode (ten's-complement result with a negative flag) and invalid-digit detection.
- Sits between the operand register file and the display/result path; replaces the purely combinational 8-digit adder where area matters more than latency.

Parameters:
- WIDTH, 8, number of BCD digits per operand/result; must be >= 1.
- DPC, 2, digits processed per clock; must be >= 1 and divide WIDTH exactly (elaboration-time assertion).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and op are valid
- in_ready  output  1  block can accept an operation
- op  input  1  0 = add (a+b), 1 = subtract (a-b)
- a  input  [3:0] x WIDTH (unpacked, index 0 = LS digit)  operand A
- b  input  [3:0] x WIDTH (unpacked, index 0 = LS digit)  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- s  output  [3:0] x WIDTH (unpacked)  result digits
- cout  output  1  add: decimal carry out of MS digit; sub: final carry (1 = no borrow)
- neg  output  1  sub only: result negative (= ~cout); 0 in add mode
- err  output  1  some input digit of a or b was > 9

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; s all 0; cout=0; neg=0; err=0; group index=0; internal carry=0. Reset mid-operation abandons the operation; no output is produced.
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a, b and op.
  - Clear the group index; carry := op.
  - err := OR over all digits (a[i]>9 or b[i]>9).
  - Go to RUN.
- State RUN:
  - in_ready=0.
  - Each edge processes digits idx*DPC .. idx*DPC+DPC-1 as a ripple chain of DPC digit cells.
  - Per digit: bd = op ? 9-b[i] : b[i]; t = a[i]+bd+cin (5-bit); if t >= 10 then s=t-10, cout=1, else s=t, cout=0.
  - The group carry-out is registered for the next group.
  - After the edge that processes group WIDTH/DPC-1: go to DONE and register the final carry.
- State DONE:
  - out_valid=1.
  - s, cout, neg and err are stable until the handshake.
  - On an edge with out_ready=1: go to IDLE; out_valid drops.
  - in_ready stays 0 in DONE, so a new operation is accepted no earlier than the cycle after result hand-off.
  - No input backpressure bypass.
- Latency:
  - Acceptance edge E0; out_valid is high from edge E(WIDTH/DPC).
  - Example: WIDTH=8, DPC=2 gives 4 cycles.
  - Throughput is one operation per WIDTH/DPC+2 cycles when out_ready is held high.
- Subtract semantics:
  - If a >= b: s = a-b, cout=1, neg=0.
  - If a < b: s = ten's complement 10^WIDTH-(b-a), cout=0, neg=1.
- err=1: s is forced to all zero, and cout=0, neg=0 in DONE; the operation still takes full latency.
- Digits of s not yet computed are don't-care until out_valid is asserted. The bench samples s only when out_valid=1.
- in_valid is sampled only in IDLE. Operand changes during RUN/DONE are ignored because operands are latched.
- DPC=WIDTH: a single RUN cycle, so latency is 1.

Decomposition:
- Shared package bcd_pkg:
  - typedef bcd_digit_t (logic [3:0]).
  - enum op_e {OP_ADD, OP_SUB}.
  - enum state_e {IDLE, RUN, DONE}.
  - constant BCD_MAX_DIGIT = 9.
  - function is_bcd(bcd_digit_t).
- Sub-module bcd_digit_cell: combinational single-digit cell with inputs a, b, cin, sub and outputs s, cout (performs the 9's complement internally). It is instantiated DPC times via generate inside the group datapath.
- The FSM, carry register and operand registers live in the top module.

Test Plan:
- Add, WIDTH=8, DPC=2: a=00000019, b=00000028, op=0 -> s=00000047, cout=0, neg=0, err=0; out_valid exactly 4 cycles after acceptance.
- Add full carry: a=99999999, b=00000001 -> s=00000000, cout=1. Also a=99999999, b=99999999 -> s=99999998, cout=1.
- Subtract: a=00001000, b=00000001, op=1 -> s=00000999, cout=1, neg=0. Also a=00000003, b=00000005 -> s=99999998, cout=0, neg=1.
- Invalid digit: a=0000000A, b=00000001 -> err=1, s=00000000, cout=0; the next valid op (1+1) -> s=00000002, err=0.
- Handshake/backpressure:
  - Hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0, a second in_valid is ignored.
  - Then assert out_ready -> in_ready returns to 1 the next cycle and the queued op is accepted.
  - Assert rst_n=0 mid-RUN -> immediate IDLE, out_valid=0, all outputs zero.
- Parameter sweep: DPC in {1,2,4,8} with WIDTH=8, plus WIDTH=1/DPC=1 -> random add/sub matches a decimal reference model; latency equals WIDTH/DPC.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, op/state encodings and digit validity helper
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  typedef enum logic {OP_ADD, OP_SUB} op_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
  function automatic logic is_bcd(bcd_digit_t d);
    return d <= BCD_MAX_DIGIT;
  endfunction
endpackage

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: one decimal digit of add, or of subtract via nine's complement of b
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] bd;
  logic [4:0] t;
  always_comb begin
    bd = sub ? BCD_MAX_DIGIT - b : b;
    t = {1'b0, a} + {1'b0, bd} + {4'd0, cin};
    cout = t >= 5'd10;
    s = cout ? 4'(t - 5'd10) : t[3:0];
  end
endmodule

// File: rtl/bcd_addsub_seq.sv
// bcd_addsub_seq: digit-serial BCD add/subtract, DPC digits per clock behind valid/ready
module bcd_addsub_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DPC   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       op,
  input  logic [3:0] a [WIDTH],
  input  logic [3:0] b [WIDTH],
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] s [WIDTH],
  output logic       cout,
  output logic       neg,
  output logic       err
);
  localparam int NG = WIDTH / DPC;
  localparam int IW = NG > 1 ? $clog2(NG) : 1;
  if (WIDTH < 1 || DPC < 1 || WIDTH % DPC != 0) begin : g_bad_param
    $error("bcd_addsub_seq: DPC must be >= 1 and divide WIDTH exactly");
  end
  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry, op_r, bad, accept, running, last;
  logic [3:0]    a_r [WIDTH], b_r [WIDTH], s_r [WIDTH];
  logic [3:0]    a_nx [WIDTH], b_nx [WIDTH], s_nx [WIDTH];
  logic [3:0]    cs [DPC], sc [DPC];
  logic [DPC:0]  c;
  assign accept    = state == IDLE && in_valid;
  assign running   = state == RUN;
  assign last      = idx == IW'(NG - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign s         = s_r;
  assign c[0]      = carry;
  // Operands shift down each RUN cycle, so the active group always sits in digits 0..DPC-1
  for (genvar j = 0; j < DPC; j++) begin : g_cell
    bcd_digit_cell u_cell (
      .a    (a_r[j]),
      .b    (b_r[j]),
      .cin  (c[j]),
      .sub  (op_r),
      .s    (cs[j]),
      .cout (c[j+1])
    );
  end
  // Results enter at the top and shift down, landing in place after the last group
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < WIDTH; i++) bad |= !is_bcd(a[i]) || !is_bcd(b[i]);
    for (int i = 0; i < DPC; i++) sc[i] = err ? 4'd0 : cs[i];
    for (int i = 0; i < WIDTH; i++) begin
      a_nx[i] = i < WIDTH - DPC ? a_r[(i + DPC) % WIDTH] : 4'd0;
      b_nx[i] = i < WIDTH - DPC ? b_r[(i + DPC) % WIDTH] : 4'd0;
      s_nx[i] = i < WIDTH - DPC ? s_r[(i + DPC) % WIDTH] : sc[i % DPC];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      op_r  <= 1'b0;
      err   <= 1'b0;
      cout  <= 1'b0;
      neg   <= 1'b0;
      a_r   <= '{default: '0};
      b_r   <= '{default: '0};
      s_r   <= '{default: '0};
    end else if (accept) begin
      state <= RUN;
      idx   <= '0;
      carry <= op;
      op_r  <= op;
      err   <= bad;
      cout  <= 1'b0;
      neg   <= 1'b0;
      a_r   <= a;
      b_r   <= b;
    end else if (running) begin
      a_r   <= a_nx;
      b_r   <= b_nx;
      s_r   <= s_nx;
      carry <= c[DPC];
      idx   <= idx + 1'b1;
      if (last) begin
        state <= DONE;
        cout  <= ~err & c[DPC];
        neg   <= ~err & op_r & ~c[DPC];
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_bcd_addsub_seq.sv
// tb_bcd_addsub_seq: vector table, handshake corner cases and per-configuration random sweep
module tb_bcd_addsub_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0, errors = 0, checks = 0, done_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic o;
    logic [31:0] a, b, s;
    logic cout, neg, err;
  } vec_t;
  typedef struct {
    logic [34:0] e;
    int acc;
  } exp_t;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // decimal reference: returns {err, neg, cout, s}
  function automatic logic [34:0] ref_model(logic o, logic [31:0] av, logic [31:0] bv, int w);
    longint x = 0, y = 0, m = 1, r;
    logic e = 1'b0, c;
    logic [31:0] sv = '0;
    for (int i = w - 1; i >= 0; i--) begin
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) e = 1'b1;
      x = x * 10 + longint'(av[4*i +: 4]);
      y = y * 10 + longint'(bv[4*i +: 4]);
      m = m * 10;
    end
    r = o ? x + m - y : x + y;
    c = r >= m;
    if (c) r = r - m;
    for (int i = 0; i < w; i++) begin
      sv[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return e ? {3'b100, 32'd0} : {1'b0, o & ~c, c, sv};
  endfunction

  for (genvar g = 0; g < 5; g++) begin : g_cfg
    localparam int W  = g == 4 ? 1 : 8;
    localparam int D  = g == 0 ? 2 : g == 1 ? 1 : g == 2 ? 4 : g == 3 ? 8 : 1;
    localparam int NG = W / D;
    logic rst_n, in_valid, in_ready, op, out_valid, out_ready, cout, neg, err;
    logic [3:0] a [W], b [W], s [W];
    logic [31:0] s_pk;
    exp_t q [$];
    bit seen = 1'b0;

    bcd_addsub_seq #(.WIDTH(W), .DPC(D)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .s(s),
      .cout(cout), .neg(neg), .err(err)
    );

    always_comb begin
      s_pk = '0;
      for (int i = 0; i < W; i++) s_pk[4*i +: 4] = s[i];
    end

    always @(negedge clk) begin
      if (out_valid) begin
        if (q.size() == 0) chk($sformatf("c%0d_unexpected_out", g), 64'(1), 64'(0));
        else begin
          if (!seen) begin
            chk($sformatf("c%0d_latency", g), 64'(cyc - q[0].acc), 64'(NG));
            seen = 1'b1;
          end
          if (out_ready) begin
            chk($sformatf("c%0d_sum", g), 64'(s_pk), 64'(q[0].e[31:0]));
            chk($sformatf("c%0d_err_neg_cout", g), 64'({err, neg, cout}), 64'(q[0].e[34:32]));
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end

    task automatic set_ops(logic o, logic [31:0] av, logic [31:0] bv);
      op = o;
      for (int i = 0; i < W; i++) begin
        a[i] = av[4*i +: 4];
        b[i] = bv[4*i +: 4];
      end
    endtask

    task automatic send(logic o, logic [31:0] av, logic [31:0] bv, logic [34:0] e);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) chk($sformatf("c%0d_send_timeout", g), 64'(0), 64'(1));
      else begin
        set_ops(o, av, bv);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        q.push_back('{e, cyc});
      end
    endtask

    task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("c%0d_drain", g), 64'(q.size()), 64'(0));
    endtask

    task automatic rand_ops(int cnt);
      logic [31:0] av, bv;
      logic o;
      for (int k = 0; k < cnt; k++) begin
        av = '0;
        bv = '0;
        o = 1'($urandom_range(0, 1));
        for (int i = 0; i < W; i++) begin
          av[4*i +: 4] = k % 5 == 0 ? 4'd9 : 4'($urandom_range(0, 9));
          bv[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        send(o, av, bv, ref_model(o, av, bv, W));
      end
    endtask

    if (g == 0) begin : g_dir
      initial begin
        vec_t v [8];
        logic [34:0] snap;
        logic stable;
        int n;
        v = '{
          '{1'b0, 32'h00000019, 32'h00000028, 32'h00000047, 1'b0, 1'b0, 1'b0},
          '{1'b0, 32'h99999999, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0},
          '{1'b0, 32'h99999999, 32'h99999999, 32'h99999998, 1'b1, 1'b0, 1'b0},
          '{1'b1, 32'h00001000, 32'h00000001, 32'h00000999, 1'b1, 1'b0, 1'b0},
          '{1'b1, 32'h00000003, 32'h00000005, 32'h99999998, 1'b0, 1'b1, 1'b0},
          '{1'b0, 32'h0000000A, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1},
          '{1'b0, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b0},
          '{1'b1, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0}
        };
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_ops(1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        chk("c0_reset_state", 64'({in_ready, out_valid, s_pk, cout, neg, err}), 64'({1'b1, 1'b0, 32'd0, 3'd0}));
        rst_n = 1'b1;
        foreach (v[i]) send(v[i].o, v[i].a, v[i].b, {v[i].err, v[i].neg, v[i].cout, v[i].s});
        drain();
        // hold the result under backpressure while a second request waits
        out_ready = 1'b0;
        send(1'b0, 32'h2, 32'h3, {3'b000, 32'h5});
        n = 0;
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("c0_out_valid_rise", 64'(out_valid), 64'(1));
        snap = {s_pk, cout, neg, err};
        stable = 1'b1;
        set_ops(1'b0, 32'h7, 32'h1);
        in_valid = 1'b1;
        repeat (10) begin
          @(negedge clk);
          stable &= ({s_pk, cout, neg, err} == snap) && out_valid && !in_ready;
        end
        chk("c0_hold_stable", 64'(stable), 64'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("c0_in_ready_back", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("c0_queued_accept", 64'(in_ready), 64'(0));
        q.push_back('{{3'b000, 32'h8}, cyc});
        drain();
        // reset in the middle of RUN abandons the operation
        @(negedge clk);
        set_ops(1'b0, 32'h12345678, 32'h11111111);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("c0_reset_midrun", 64'({in_ready, out_valid, s_pk, cout, neg, err}), 64'({1'b1, 1'b0, 32'd0, 3'd0}));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        send(1'b1, 32'h5, 32'h3, {3'b001, 32'h2});
        rand_ops(20);
        drain();
        done_cnt++;
      end
    end else begin : g_rnd
      initial begin
        out_ready = 1'b1;
        forever begin
          @(posedge clk);
          #1;
          out_ready = $urandom_range(0, 3) != 0;
        end
      end
      initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        set_ops(1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rand_ops(25);
        drain();
        done_cnt++;
      end
    end
  end

  initial begin
    int n = 0;
    while (done_cnt < 5 && n < 50000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < 5) begin
      checks++;
      errors++;
      $display("FAIL global_timeout: got %0d finished configs want 5", done_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
